// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/align path.
// The compressed-instruction helper is only referenced when FETCH_COMPRESSED_EN is defined.
package fetch_pkg;

  localparam int unsigned ILEN     = 32;
  localparam int unsigned HW_BYTES = 2;
  localparam logic [1:0]  RVC_MASK = 2'b11;

  typedef logic [15:0] hw_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [31:0]     pc;
    logic            compressed;
  } fetch_out_t;

  // A halfword starts a 16-bit instruction unless its two low bits are both set.
  function automatic logic isCompressed(input hw_t hw);
    return (hw[1:0] & RVC_MASK) != RVC_MASK;
  endfunction

endpackage

// File: rtl/fetch_aligner_if.sv
// Fetch-side bus: program memory port, branch redirect and the decode valid/ready handshake.
// The master modport is the fetch aligner; the slave modport is its environment.
interface fetch_aligner_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;

  modport master (
    output mem_addr,
    input  mem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_compressed
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_compressed
  );

endinterface

// File: rtl/fetch_hw_queue.sv
// Circular halfword FIFO between program memory and the aligner.
// Accepts 0-2 halfwords and releases 0-2 halfwords per cycle; flush empties it at once.
module fetch_hw_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic [1:0]       pushCnt_i,
  input  hw_t              pushHw0_i,
  input  hw_t              pushHw1_i,
  input  logic [1:0]       popCnt_i,
  output hw_t              hw0_o,
  output hw_t              hw1_o,
  output logic [OCC_W-1:0] occ_o
);

  hw_t              storage_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  // DEPTH may be 6, so pointers wrap explicitly rather than by overflow.
  function automatic logic [PTR_W-1:0] ptrAdd(input logic [PTR_W-1:0] ptr, input logic [1:0] n);
    logic [31:0] sum;
    sum = 32'(ptr) + 32'(n);
    if (sum >= 32'(DEPTH)) begin
      sum = sum - 32'(DEPTH);
    end
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    rdPtr_d = ptrAdd(rdPtr_q, popCnt_i);
    wrPtr_d = ptrAdd(wrPtr_q, pushCnt_i);
    occ_d   = occ_q - OCC_W'(popCnt_i) + OCC_W'(pushCnt_i);
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      occ_q   <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      occ_q   <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (pushCnt_i != 2'd0) begin
        storage_q[wrPtr_q] <= pushHw0_i;
      end
      if (pushCnt_i == 2'd2) begin
        storage_q[ptrAdd(wrPtr_q, 2'd1)] <= pushHw1_i;
      end
    end
  end

  assign hw0_o = storage_q[rdPtr_q];
  assign hw1_o = storage_q[ptrAdd(rdPtr_q, 2'd1)];
  assign occ_o = occ_q;

endmodule

// File: rtl/fetch_aligner.sv
// Fetch stage: walks program memory word by word and hands aligned RV32 instructions to decode.
// Define FETCH_COMPRESSED_EN to extract 16-bit RVC instructions; otherwise every instruction is 32-bit.
module fetch_aligner
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned BUF_HW   = 4
) (
  input logic             clk,
  input logic             reset,
  fetch_aligner_if.master bus
);

  localparam int unsigned OCC_W = $clog2(BUF_HW + 1);

  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occAfterPop;
  hw_t              hw0, hw1;
  hw_t              pushHw0, pushHw1;
  logic [1:0]       pushCnt, popCnt;
  logic [31:0]      fetchAddr_q, fetchAddr_d;
  logic [31:0]      headPc_q, headPc_d;
  logic             dropLo_q, dropLo_d;
  logic             headIs16;
  logic             outValid;
  logic             transfer;
  logic             fill;
  fetch_out_t       outData;
  logic [1:0]       unusedPcBits;

  fetch_hw_queue #(
    .DEPTH (BUF_HW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (bus.redirect_valid),
    .pushCnt_i (pushCnt),
    .pushHw0_i (pushHw0),
    .pushHw1_i (pushHw1),
    .popCnt_i  (popCnt),
    .hw0_o     (hw0),
    .hw1_o     (hw1),
    .occ_o     (occ)
  );

`ifdef FETCH_COMPRESSED_EN
  assign headIs16 = isCompressed(hw0);
`else
  assign headIs16 = 1'b0;
`endif

  assign unusedPcBits = bus.redirect_pc[1:0];

  // Length decode of the head: the instruction is ready once all of its halfwords are buffered.
  always_comb begin
    outValid = (occ >= OCC_W'(2)) || (headIs16 && (occ != '0));
    outData  = '0;
    if (outValid) begin
      outData.instr      = headIs16 ? {16'h0000, hw0} : {hw1, hw0};
      outData.pc         = headPc_q;
      outData.compressed = headIs16;
    end
  end

  // A redirect in the same cycle cancels the transfer of whatever is being presented.
  always_comb begin
    transfer    = outValid && bus.out_ready && !bus.redirect_valid;
    popCnt      = 2'd0;
    if (transfer) begin
      popCnt = headIs16 ? 2'd1 : 2'd2;
    end
    occAfterPop = occ - OCC_W'(popCnt);
    fill        = !bus.redirect_valid && (occAfterPop <= OCC_W'(BUF_HW - 2));
    pushCnt     = 2'd0;
    pushHw0     = bus.mem_rdata[15:0];
    pushHw1     = bus.mem_rdata[31:16];
    if (fill) begin
      if (dropLo_q) begin
        pushCnt = 2'd1;
        pushHw0 = bus.mem_rdata[31:16];
      end else begin
        pushCnt = 2'd2;
      end
    end
  end

  always_comb begin
    fetchAddr_d = fetchAddr_q;
    headPc_d    = headPc_q + 32'(popCnt) * 32'(HW_BYTES);
    dropLo_d    = dropLo_q;
    if (fill) begin
      fetchAddr_d = fetchAddr_q + 32'd4;
      dropLo_d    = 1'b0;
    end
    if (bus.redirect_valid) begin
      fetchAddr_d = {bus.redirect_pc[31:2], 2'b00};
`ifdef FETCH_COMPRESSED_EN
      headPc_d    = {bus.redirect_pc[31:1], 1'b0};
      dropLo_d    = bus.redirect_pc[1];
`else
      headPc_d    = {bus.redirect_pc[31:2], 2'b00};
      dropLo_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchAddr_q <= RESET_PC;
      headPc_q    <= RESET_PC;
      dropLo_q    <= 1'b0;
    end else begin
      fetchAddr_q <= fetchAddr_d;
      headPc_q    <= headPc_d;
      dropLo_q    <= dropLo_d;
    end
  end

  assign bus.mem_addr       = fetchAddr_q;
  assign bus.out_valid      = outValid;
  assign bus.out_instr      = outData.instr;
  assign bus.out_pc         = outData.pc;
  assign bus.out_compressed = outData.compressed;

endmodule
